// File: rtl/conv_pkg.sv
// Shared types and helpers for the 1x1 conv tile sequencer.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ISSUE,
    WAIT,
    DONE
  } seq_state_e;

  localparam int TILE_LEN_LOG2 = 4;

  // Ceiling of x / 2**sh; the 32-bit intermediate leaves headroom for the rounding bias.
  function automatic logic [31:0] ceil_div_pow2(input logic [31:0] x, input logic [4:0] sh);
    return (x + ((32'd1 << sh) - 32'd1)) >> sh;
  endfunction

endpackage

// File: rtl/conv_tile_iter.sv
// Square 2-D tile counter: row-major order with the column as the inner index.
module conv_tile_iter
  import conv_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         step,
  input  logic [W-1:0] last_idx,
  output logic [W-1:0] row_idx,
  output logic [W-1:0] col_idx,
  output logic         last_row,
  output logic         last_col,
  output logic         last_tile
);

  logic [W-1:0] lim;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_idx <= '0;
      col_idx <= '0;
      lim     <= '0;
    end else if (clear) begin
      row_idx <= '0;
      col_idx <= '0;
      lim     <= last_idx;
    end else if (step) begin
      if (last_col) begin
        col_idx <= '0;
        row_idx <= row_idx + 1'b1;
      end else begin
        col_idx <= col_idx + 1'b1;
      end
    end
  end

  assign last_row  = (row_idx == lim);
  assign last_col  = (col_idx == lim);
  assign last_tile = last_row && last_col;

endmodule

// File: rtl/conv1x1_tile_seq.sv
// Job-level tile sequencer for the 1x1 conv datapath.
// Optional CONV_TILE_PERF_EN adds busy/wait cycle counters.
module conv1x1_tile_seq
  import conv_pkg::*;
#(
  parameter int CHN_WIDTH    = 6,
  parameter int FMS_WIDTH    = 8,
  parameter int TILE_LEN     = 1 << TILE_LEN_LOG2,
  parameter int STRIDE_WIDTH = 2,
  parameter int TIDX_WIDTH   = 4
`ifdef CONV_TILE_PERF_EN
  ,
  parameter int PERF_WIDTH   = 32
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [CHN_WIDTH-1:0]         cfg_ci,
  input  logic [CHN_WIDTH-1:0]         cfg_co,
  input  logic [STRIDE_WIDTH-1:0]      cfg_stride_log2,
  input  logic [FMS_WIDTH-1:0]         cfg_ifm_size,
  input  logic                         abort,
  input  logic                         kern_done,
  output logic [CHN_WIDTH-1:0]         chi,
  output logic [CHN_WIDTH-1:0]         cho,
  output logic [STRIDE_WIDTH-1:0]      stride_log2,
  output logic [FMS_WIDTH-1:0]         ofm_size,
  output logic                         tile_start,
  output logic [TIDX_WIDTH-1:0]        tile_row_idx,
  output logic [TIDX_WIDTH-1:0]        tile_col_idx,
  output logic [$clog2(TILE_LEN)-1:0]  tile_row_max,
  output logic [$clog2(TILE_LEN)-1:0]  tile_col_max,
  output logic                         busy,
  output logic                         job_done,
  output logic                         job_aborted
`ifdef CONV_TILE_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0]        perf_busy_cyc,
  output logic [PERF_WIDTH-1:0]        perf_wait_cyc
`endif
);

  localparam int TLOG = $clog2(TILE_LEN);

  seq_state_e             state;
  logic [FMS_WIDTH-1:0]   ifm_q;
  logic [TLOG-1:0]        last_max_q;

  logic [FMS_WIDTH-1:0]   ofm_c;
  logic [TIDX_WIDTH-1:0]  last_idx_c;
  logic [TLOG-1:0]        last_max_c;
  logic                   take_abort;
  logic                   it_clear;
  logic                   it_step;
  logic                   it_last_row;
  logic                   it_last_col;
  logic                   it_last;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ofm_c      = FMS_WIDTH'(ceil_div_pow2(32'(ifm_q), 5'(stride_log2)));
    last_idx_c = '0;
    last_max_c = '0;
    if (ofm_c != '0) begin
      last_idx_c = TIDX_WIDTH'(ceil_div_pow2(32'(ofm_c), 5'(TLOG)) - 32'd1);
      last_max_c = TLOG'(ofm_c - 1'b1);
    end
    take_abort = abort && (state != IDLE);
    // Indices reload on the CALC->ISSUE edge so they only move when entering ISSUE.
    it_clear   = take_abort || (state == CALC);
    it_step    = (state == WAIT) && kern_done && !abort && !it_last;
  end

  conv_tile_iter #(.W(TIDX_WIDTH)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .clear     (it_clear),
    .step      (it_step),
    .last_idx  (last_idx_c),
    .row_idx   (tile_row_idx),
    .col_idx   (tile_col_idx),
    .last_row  (it_last_row),
    .last_col  (it_last_col),
    .last_tile (it_last)
  );

  assign tile_row_max = it_last_row ? last_max_q : '1;
  assign tile_col_max = it_last_col ? last_max_q : '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cfg_ready   <= 1'b1;
      busy        <= 1'b0;
      tile_start  <= 1'b0;
      job_done    <= 1'b0;
      job_aborted <= 1'b0;
      chi         <= '0;
      cho         <= '0;
      stride_log2 <= '0;
      ofm_size    <= '0;
      ifm_q       <= '0;
      last_max_q  <= '0;
    end else begin
      tile_start  <= 1'b0;
      job_done    <= 1'b0;
      job_aborted <= 1'b0;
      if (state == IDLE) begin
        if (cfg_valid) begin
          chi         <= cfg_ci;
          cho         <= cfg_co;
          stride_log2 <= cfg_stride_log2;
          ifm_q       <= cfg_ifm_size;
          state       <= CALC;
          busy        <= 1'b1;
          cfg_ready   <= 1'b0;
        end
      end else if (take_abort) begin
        state       <= IDLE;
        busy        <= 1'b0;
        cfg_ready   <= 1'b1;
        job_aborted <= 1'b1;
        last_max_q  <= '0;
      end else begin
        case (state)
          CALC: begin
            ofm_size   <= ofm_c;
            last_max_q <= last_max_c;
            if (ofm_c == '0) begin
              state    <= DONE;
              job_done <= 1'b1;
            end else begin
              state      <= ISSUE;
              tile_start <= 1'b1;
            end
          end
          ISSUE: state <= WAIT;
          WAIT: begin
            if (kern_done) begin
              if (it_last) begin
                state    <= DONE;
                job_done <= 1'b1;
              end else begin
                state      <= ISSUE;
                tile_start <= 1'b1;
              end
            end
          end
          DONE: begin
            state     <= IDLE;
            busy      <= 1'b0;
            cfg_ready <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef CONV_TILE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && cfg_valid)) begin
      perf_busy_cyc <= '0;
      perf_wait_cyc <= '0;
    end else begin
      if (state != IDLE && !(&perf_busy_cyc)) perf_busy_cyc <= perf_busy_cyc + 1'b1;
      if (state == WAIT && !(&perf_wait_cyc)) perf_wait_cyc <= perf_wait_cyc + 1'b1;
    end
  end
`else
  // Counters are compiled out in the default build.
`endif

endmodule

// File: tb/tb_conv1x1_tile_seq.sv
// Self-checking bench for conv1x1_tile_seq: table, random jobs and abort/reset corner cases.
module tb_conv1x1_tile_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_ci, cfg_co;
  logic [1:0] cfg_stride_log2;
  logic [7:0] cfg_ifm_size;
  logic       abort, kern_done;
  logic [5:0] chi, cho;
  logic [1:0] stride_log2;
  logic [7:0] ofm_size;
  logic       tile_start;
  logic [3:0] tile_row_idx, tile_col_idx, tile_row_max, tile_col_max;
  logic       busy, job_done, job_aborted;
`ifdef CONV_TILE_PERF_EN
  logic [31:0] perf_busy_cyc, perf_wait_cyc;
`endif

  always #5 clk = ~clk;

  conv1x1_tile_seq dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_ci          (cfg_ci),
    .cfg_co          (cfg_co),
    .cfg_stride_log2 (cfg_stride_log2),
    .cfg_ifm_size    (cfg_ifm_size),
    .abort           (abort),
    .kern_done       (kern_done),
    .chi             (chi),
    .cho             (cho),
    .stride_log2     (stride_log2),
    .ofm_size        (ofm_size),
    .tile_start      (tile_start),
    .tile_row_idx    (tile_row_idx),
    .tile_col_idx    (tile_col_idx),
    .tile_row_max    (tile_row_max),
    .tile_col_max    (tile_col_max),
    .busy            (busy),
    .job_done        (job_done),
    .job_aborted     (job_aborted)
`ifdef CONV_TILE_PERF_EN
    ,
    .perf_busy_cyc   (perf_busy_cyc),
    .perf_wait_cyc   (perf_wait_cyc)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: output side is the ceiling of ifm over the stride.
  function automatic int model_ofm(input int ifm, input int s);
    int d;
    d = 1 << s;
    if (ifm % d != 0) return ifm / d + 1;
    return ifm / d;
  endfunction

  // Drive one complete job; kern_done arrives lat cycles after each tile_start.
  task automatic run_job(input int ifm, input int s, input int lat, input int ci, input int co,
                         output int started);
    int ofm, n, lm, emax_r, emax_c;
    ofm = model_ofm(ifm, s);
    n   = (ofm + 15) / 16;
    lm  = (ofm > 0) ? (ofm - 1) % 16 : 0;
    started = 0;
    cfg_valid = 1'b1; cfg_ifm_size = 8'(ifm); cfg_stride_log2 = 2'(s);
    cfg_ci = 6'(ci); cfg_co = 6'(co);
    tick();
    cfg_valid = 1'b0;
    check("calc_busy", busy, 1);
    check("calc_ready", cfg_ready, 0);
    check("calc_no_start", tile_start, 0);
    tick();
    if (ofm == 0) begin
      check("empty_done", job_done, 1);
      check("empty_no_start", tile_start, 0);
      check("empty_busy", busy, 1);
      tick();
      check("empty_idle", busy, 0);
      check("empty_ready", cfg_ready, 1);
`ifdef CONV_TILE_PERF_EN
      check("empty_perf_busy", perf_busy_cyc, 2);
`endif
      return;
    end
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        emax_r = (r == n - 1) ? lm : 15;
        emax_c = (c == n - 1) ? lm : 15;
        check("tile_start", tile_start, 1);
        if (tile_start === 1'b1) started++;
        check("row_idx", tile_row_idx, r);
        check("col_idx", tile_col_idx, c);
        check("row_max", tile_row_max, emax_r);
        check("col_max", tile_col_max, emax_c);
        check("no_early_done", job_done, 0);
        if (r == 0 && c == 0) begin
          check("chi", chi, ci);
          check("cho", cho, co);
          check("stride", stride_log2, s);
          check("ofm", ofm_size, ofm);
        end
        repeat (lat) begin
          tick();
          check("wait_no_start", tile_start, 0);
        end
        check("wait_idx_hold", tile_col_idx, c);
        kern_done = 1'b1;
        tick();
        kern_done = 1'b0;
      end
    end
    check("job_done", job_done, 1);
    check("done_busy", busy, 1);
    check("done_no_start", tile_start, 0);
    tick();
    check("done_pulse_once", job_done, 0);
    check("end_idle", busy, 0);
    check("end_ready", cfg_ready, 1);
`ifdef CONV_TILE_PERF_EN
    check("perf_wait", perf_wait_cyc, n * n * lat);
    check("perf_busy", perf_busy_cyc, 2 + n * n * (1 + lat));
`endif
  endtask

  typedef struct {
    int ifm;
    int s;
    int lat;
    int exp_ofm;
    int exp_tiles;
  } vec_t;

  vec_t vecs[6];
  int   got;

  initial begin
    vecs[0] = '{32, 0, 1, 32, 4};
    vecs[1] = '{37, 1, 2, 19, 4};
    vecs[2] = '{0, 0, 1, 0, 0};
    vecs[3] = '{16, 0, 10, 16, 1};
    vecs[4] = '{255, 3, 1, 32, 4};
    vecs[5] = '{1, 3, 3, 1, 1};

    rst = 1'b1; cfg_valid = 1'b0; cfg_ci = '0; cfg_co = '0; cfg_stride_log2 = '0;
    cfg_ifm_size = '0; abort = 1'b0; kern_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", tile_start, 0);
    check("rst_done", job_done, 0);
    check("rst_aborted", job_aborted, 0);
    check("rst_ofm", ofm_size, 0);
    check("rst_row_max", tile_row_max, 0);
    check("rst_col_max", tile_col_max, 0);

    // abort and kern_done in IDLE have no effect
    abort = 1'b1; kern_done = 1'b1;
    tick();
    abort = 1'b0; kern_done = 1'b0;
    check("idle_abort_ignored", job_aborted, 0);
    check("idle_stays", busy, 0);

    for (int i = 0; i < 6; i++) begin
      run_job(vecs[i].ifm, vecs[i].s, vecs[i].lat, 5 + i, 40 - i, got);
      check("vec_ofm", ofm_size, vecs[i].exp_ofm);
      check("vec_tiles", got, vecs[i].exp_tiles);
    end

    for (int i = 0; i < 10; i++) begin
      run_job(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
              int'($urandom_range(1, 3)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 63)), got);
    end

    // Abort while waiting on the second tile
    cfg_valid = 1'b1; cfg_ifm_size = 8'd32; cfg_stride_log2 = 2'd0; cfg_ci = 6'd9; cfg_co = 6'd10;
    tick(); cfg_valid = 1'b0;
    tick();
    check("ab_first_start", tile_start, 1);
    tick();
    kern_done = 1'b1;
    tick();
    kern_done = 1'b0;
    check("ab_second_col", tile_col_idx, 1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_pulse", job_aborted, 1);
    check("ab_ready", cfg_ready, 1);
    check("ab_idle", busy, 0);
    check("ab_no_done", job_done, 0);
    check("ab_idx_clr", tile_col_idx, 0);
    check("ab_chi_held", chi, 9);
    tick();
    check("ab_pulse_once", job_aborted, 0);
    check("ab_no_stale_done", job_done, 0);
    run_job(32, 0, 2, 3, 4, got);
    check("ab_restart_tiles", got, 4);

    // Config with abort in IDLE is accepted; kern_done in ISSUE ignored; abort beats kern_done
    cfg_valid = 1'b1; abort = 1'b1; cfg_ifm_size = 8'd32; cfg_stride_log2 = 2'd0;
    tick();
    cfg_valid = 1'b0; abort = 1'b0;
    check("cfg_abort_accept", busy, 1);
    check("cfg_abort_no_pulse", job_aborted, 0);
    tick();
    check("k5_start", tile_start, 1);
    kern_done = 1'b1;
    tick();
    kern_done = 1'b0;
    check("k5_issue_ignored", tile_start, 0);
    tick();
    check("k5_still_waiting", tile_start, 0);
    check("k5_idx_hold", tile_col_idx, 0);
    kern_done = 1'b1; abort = 1'b1;
    tick();
    kern_done = 1'b0; abort = 1'b0;
    check("k5_abort_wins", job_aborted, 1);
    check("k5_no_start", tile_start, 0);
    check("k5_no_done", job_done, 0);
    tick();
    check("k5_quiet", tile_start, 0);
    check("k5_idle", busy, 0);

    // Reset in the middle of a job
    cfg_valid = 1'b1; cfg_ifm_size = 8'd64; cfg_ci = 6'd33;
    tick(); cfg_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_ready", cfg_ready, 1);
    check("mrst_no_abort", job_aborted, 0);
    check("mrst_no_done", job_done, 0);
    check("mrst_chi", chi, 0);
    run_job(20, 2, 1, 1, 2, got);
    check("mrst_after_tiles", got, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
